// File: rtl/perf_counter_display.sv
// Shows one of the four PC statistics counters as 8 hex digits on a multiplexed,
// active-low seven-segment display. The value is snapshotted once per scan frame.
module perf_counter_display #(
  parameter int SCAN_DIV   = 100000,
  parameter bit ZERO_BLANK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  select,
  input  logic        freeze,
  input  logic [31:0] totalCycle,
  input  logic [31:0] unconditionalJump,
  input  logic [31:0] conditionalJump,
  input  logic [31:0] conditionalSuccessfulJump,
  output logic [7:0]  anode,
  output logic [7:0]  segments,
  output logic        frameDone
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic [2:0]    digit_index;
  logic [31:0]   snapshot;
  logic [1:0]    sel_latched;

  logic          tick;
  logic          boundary;
  logic [31:0]   chosen;
  logic [3:0]    nibble;
  logic          upper_zero;
  logic          blank;
  logic [6:0]    glyph;
  logic [7:0]    seg_next;

  assign tick     = (prescaler == PW'(SCAN_DIV - 1));
  assign boundary = tick && (digit_index == 3'd7);

  always_comb begin
    chosen = totalCycle;
    case (select)
      2'd0:    chosen = totalCycle;
      2'd1:    chosen = unconditionalJump;
      2'd2:    chosen = conditionalJump;
      default: chosen = conditionalSuccessfulJump;
    endcase
  end

  // Scan timing and the per-frame snapshot; loads happen only on the frame boundary
  // so a whole frame always shows one coherent value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      digit_index <= 3'd0;
      snapshot    <= 32'd0;
      sel_latched <= 2'd0;
      frameDone   <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) digit_index <= digit_index + 3'd1;
      if (boundary && !freeze) begin
        snapshot    <= chosen;
        sel_latched <= select;
      end
      frameDone <= boundary && !freeze;
    end
  end

  always_comb begin
    nibble     = snapshot[{digit_index, 2'b00} +: 4];
    upper_zero = ((snapshot >> {digit_index, 2'b00}) == 32'd0);
    blank      = ZERO_BLANK && (digit_index != 3'd0) && upper_zero;
    glyph      = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    // The decimal point tags which counter is shown, so it survives blanking.
    seg_next[6:0] = blank ? 7'h7F : glyph;
    seg_next[7]   = (digit_index == {1'b0, sel_latched}) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode    <= 8'hFF;
      segments <= 8'hFF;
    end else begin
      anode    <= ~(8'b1 << digit_index);
      segments <= seg_next;
    end
  end

endmodule

// File: tb/tb_perf_counter_display.sv
// Directed bench for perf_counter_display with SCAN_DIV=4 (32-cycle frames).
module tb_perf_counter_display;

  localparam int SCAN_DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  select = 2'd0;
  logic        freeze = 1'b0;
  logic [31:0] totalCycle = 32'h0000_12AF;
  logic [31:0] unconditionalJump = 32'h1111_0000;
  logic [31:0] conditionalJump = 32'h0000_0000;
  logic [31:0] conditionalSuccessfulJump = 32'hDEAD_BEEF;
  logic [7:0]  anode;
  logic [7:0]  segments;
  logic        frameDone;

  int checks = 0;
  int errors = 0;
  int fd_seen;
  int n;
  logic [7:0] exp_q[$];
  logic [7:0] cap[8];

  perf_counter_display #(.SCAN_DIV(SCAN_DIV), .ZERO_BLANK(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .select(select),
    .freeze(freeze),
    .totalCycle(totalCycle),
    .unconditionalJump(unconditionalJump),
    .conditionalJump(conditionalJump),
    .conditionalSuccessfulJump(conditionalSuccessfulJump),
    .anode(anode),
    .segments(segments),
    .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int cnt);
    repeat (cnt) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_frame_done(output int edges);
    edges = 0;
    do begin
      @(posedge clock);
      #1;
      edges++;
    end while (!frameDone && edges < 200);
    if (!frameDone) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture(input int cnt);
    logic [7:0] pat;
    fd_seen = 0;
    for (int i = 0; i < 8; i++) cap[i] = 8'h00;
    repeat (cnt) begin
      @(posedge clock);
      #1;
      if (frameDone) fd_seen++;
      for (int i = 0; i < 8; i++) begin
        pat = 8'b1 << i;
        if (anode == ~pat) cap[i] = segments;
      end
    end
  endtask

  // exp packs digit7..digit0 from MSB to LSB.
  task automatic expect_frame(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp[8*i +: 8]);
    for (int i = 0; i < 8; i++) check($sformatf("%s_d%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp_q.pop_front()});
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_anode", {24'd0, anode}, 32'hFF);
    check("rst_segments", {24'd0, segments}, 32'hFF);
    check("rst_frame_done", {31'd0, frameDone}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("first_anode", {24'd0, anode}, 32'hFE);
    check("first_segments", {24'd0, segments}, 32'h40);
    wait_frame_done(n);
    check("first_load_latency", n + 1, 32'd32);
    capture(31);
    check("single_pulse", fd_seen, 32'd0);
    expect_frame("hex12af", 64'hFFFF_FFFF_F9A4_880E);

    // Zero value with dp marking counter 2 on a blanked digit
    select = 2'd2;
    wait_frame_done(n);
    wait_frame_done(n);
    capture(31);
    expect_frame("zero_sel2", 64'hFFFF_FFFF_FF7F_FFC0);

    // Freeze holds the snapshot across boundaries
    select = 2'd0;
    totalCycle = 32'h0000_00A5;
    wait_frame_done(n);
    wait_frame_done(n);
    capture(31);
    expect_frame("pre_freeze", 64'hFFFF_FFFF_FFFF_8812);
    freeze = 1'b1;
    totalCycle = 32'h0000_0003;
    capture(70);
    check("freeze_no_pulse", fd_seen, 32'd0);
    capture(31);
    expect_frame("frozen", 64'hFFFF_FFFF_FFFF_8812);
    freeze = 1'b0;
    wait_frame_done(n);
    check("unfreeze_within_frame", {31'd0, n <= 32}, 32'd1);
    capture(31);
    expect_frame("unfrozen", 64'hFFFF_FFFF_FFFF_FF30);

    // Select change mid-frame must not tear the current frame
    wait_frame_done(n);
    tick_n(12);
    select = 2'd3;
    conditionalSuccessfulJump = 32'h1234_5678;
    tick_n(4);
    check("midframe_anode", {24'd0, anode}, 32'hF7);
    check("midframe_segments", {24'd0, segments}, 32'hFF);
    wait_frame_done(n);
    capture(31);
    expect_frame("sel3", 64'hF9A4_B099_1282_F880);

    // Asynchronous reset mid-frame at digit 5
    wait_frame_done(n);
    tick_n(20);
    reset = 1'b1;
    #1;
    check("async_rst_anode", {24'd0, anode}, 32'hFF);
    check("async_rst_segments", {24'd0, segments}, 32'hFF);
    check("async_rst_frame_done", {31'd0, frameDone}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_anode", {24'd0, anode}, 32'hFE);
    check("post_rst_segments", {24'd0, segments}, 32'h40);
    wait_frame_done(n);
    check("post_rst_load_latency", n + 1, 32'd32);
    capture(31);
    expect_frame("post_rst", 64'hF9A4_B099_1282_F880);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
